// File: rtl/sid_write_sched.sv
// SID register-write scheduler: host address/data parser, write FIFO and clk_en-aligned issue FSM.
// Optional boot sequence compiled in with `define SID_INIT_ROM_EN.
module sid_write_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] host_tdata,
  input  logic       host_tvalid,
  output logic       host_tready,
  output logic [4:0] sid_addr,
  output logic [7:0] sid_data,
  output logic       sid_n_cs,
  output logic       busy,
  output logic       init_done,
  output logic       addr_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {P_ADDR, P_DATA} parse_t;
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} issue_t;

  parse_t      parse_state, parse_next;
  issue_t      issue_state, issue_next;

  logic [12:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt, fifo_cnt_next;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  logic [12:0] push_entry;

  logic        host_accept, host_push, latch_addr, bad_addr;
  logic [4:0]  pend_addr;

  logic [3:0]  hold_cnt, hold_next;
  logic        n_cs_next;
  logic [4:0]  addr_next;
  logic [7:0]  data_next;

  assign fifo_full   = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_cnt == '0);
  assign host_tready = init_done && !rst && (parse_state == P_ADDR || !fifo_full);
  assign host_accept = host_tvalid && host_tready;
  assign host_push   = host_accept && (parse_state == P_DATA);

`ifdef SID_INIT_ROM_EN
  logic [3:0] boot_idx;
  logic [2:0] boot_done_cnt;
  logic       boot_push;
  logic       write_done;
  logic [12:0] boot_entry;

  always_comb begin
    boot_entry = {5'h18, 8'h08};
    case (boot_idx[2:0])
      3'd0: boot_entry = {5'h18, 8'h08};
      3'd1: boot_entry = {5'h05, 8'hBE};
      3'd2: boot_entry = {5'h06, 8'hF8};
      3'd3: boot_entry = {5'h01, 8'h11};
      3'd4: boot_entry = {5'h00, 8'h25};
      3'd5: boot_entry = {5'h02, 8'h00};
      3'd6: boot_entry = {5'h03, 8'h08};
      3'd7: boot_entry = {5'h04, 8'h11};
      default: boot_entry = {5'h18, 8'h08};
    endcase
  end

  assign boot_push  = (boot_idx < 4'd8) && !fifo_full;
  assign write_done = (issue_state == S_ACTIVE) && clk_en && (hold_cnt == 4'd1);
  assign push       = boot_push || host_push;
  assign push_entry = boot_push ? boot_entry : {pend_addr, host_tdata};

  // Before init_done every completed write is a boot entry, so counting completions suffices.
  always_ff @(posedge clk) begin
    if (rst) begin
      boot_idx      <= '0;
      boot_done_cnt <= '0;
      init_done     <= 1'b0;
    end else begin
      if (boot_push)
        boot_idx <= boot_idx + 4'd1;
      if (write_done && !init_done) begin
        if (boot_done_cnt == 3'd7)
          init_done <= 1'b1;
        else
          boot_done_cnt <= boot_done_cnt + 3'd1;
      end
    end
  end
`else
  assign init_done  = 1'b1;
  assign push       = host_push;
  assign push_entry = {pend_addr, host_tdata};
`endif

  always_comb begin
    parse_next = parse_state;
    latch_addr = 1'b0;
    bad_addr   = 1'b0;
    if (host_accept) begin
      case (parse_state)
        P_ADDR: begin
          if (host_tdata > 8'h1F) begin
            bad_addr = 1'b1;
          end else begin
            latch_addr = 1'b1;
            parse_next = P_DATA;
          end
        end
        P_DATA:  parse_next = P_ADDR;
        default: parse_next = P_ADDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parse_state <= P_ADDR;
      pend_addr   <= '0;
      addr_err    <= 1'b0;
    end else begin
      parse_state <= parse_next;
      addr_err    <= bad_addr;
      if (latch_addr)
        pend_addr <= host_tdata[4:0];
    end
  end

  always_comb begin
    fifo_cnt_next = fifo_cnt;
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt + CW'(1);
      2'b01:   fifo_cnt_next = fifo_cnt - CW'(1);
      default: fifo_cnt_next = fifo_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt_next;
    end
  end

  // Issue FSM: all SID bus outputs are computed here and registered below.
  always_comb begin
    issue_next = issue_state;
    hold_next  = hold_cnt;
    n_cs_next  = sid_n_cs;
    addr_next  = sid_addr;
    data_next  = sid_data;
    pop        = 1'b0;
    case (issue_state)
      S_IDLE: begin
        if (clk_en && !fifo_empty) begin
          pop        = 1'b1;
          addr_next  = fifo_mem[rd_ptr][12:8];
          data_next  = fifo_mem[rd_ptr][7:0];
          n_cs_next  = 1'b0;
          hold_next  = 4'(HOLD_TICKS);
          issue_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (clk_en) begin
          hold_next = hold_cnt - 4'd1;
          if (hold_cnt == 4'd1) begin
            n_cs_next  = 1'b1;
            issue_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (clk_en)
          issue_next = S_IDLE;
      end
      default: issue_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_state <= S_IDLE;
      hold_cnt    <= '0;
      sid_n_cs    <= 1'b1;
      sid_addr    <= '0;
      sid_data    <= '0;
      busy        <= 1'b0;
    end else begin
      issue_state <= issue_next;
      hold_cnt    <= hold_next;
      sid_n_cs    <= n_cs_next;
      sid_addr    <= addr_next;
      sid_data    <= data_next;
      busy        <= (fifo_cnt_next != '0) || (issue_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_sid_write_sched.sv
// Directed testbench for sid_write_sched; boot-sequence checks are enabled with SID_INIT_ROM_EN.
module tb_sid_write_sched;

  localparam int EN_DIV = 8;
  localparam int HOLD   = 1;
  localparam int DEPTH  = 4;
  localparam int SPAN   = HOLD * EN_DIV;
  localparam int SPACE  = (HOLD + 2) * EN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic [7:0] host_tdata = 8'h00;
  logic       host_tvalid = 1'b0;
  logic       host_tready;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic       sid_n_cs;
  logic       busy;
  logic       init_done;
  logic       addr_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  int stall_cnt = 0;
  logic prev_ncs;
  int cs_start;

  logic [4:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int         wr_start[$];
  int         wr_span[$];

`ifdef SID_INIT_ROM_EN
  localparam logic [4:0] BOOT_A[8] = '{5'h18, 5'h05, 5'h06, 5'h01, 5'h00, 5'h02, 5'h03, 5'h04};
  localparam logic [7:0] BOOT_D[8] = '{8'h08, 8'hBE, 8'hF8, 8'h11, 8'h25, 8'h00, 8'h08, 8'h11};
  localparam logic EXP_INIT = 1'b0;
  localparam int BOOT_N = 8;
`else
  localparam logic EXP_INIT = 1'b1;
  localparam int BOOT_N = 0;
`endif

  sid_write_sched #(.FIFO_DEPTH(DEPTH), .HOLD_TICKS(HOLD)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .host_tdata(host_tdata), .host_tvalid(host_tvalid), .host_tready(host_tready),
    .sid_addr(sid_addr), .sid_data(sid_data), .sid_n_cs(sid_n_cs),
    .busy(busy), .init_done(init_done), .addr_err(addr_err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      en_cnt = en_cnt + 1;
      clk_en = ((en_cnt % EN_DIV) == 0);
    end
  end

  // Bus monitor: records each write's address/data, start cycle and low span.
  initial begin
    prev_ncs = 1'b1;
    cs_start = 0;
    forever begin
      @(negedge clk);
      if (prev_ncs === 1'b1 && sid_n_cs === 1'b0) begin
        wr_addr.push_back(sid_addr);
        wr_data.push_back(sid_data);
        wr_start.push_back(cyc);
        cs_start = cyc;
      end
      if (prev_ncs === 1'b0 && sid_n_cs === 1'b1)
        wr_span.push_back(cyc - cs_start);
      if (addr_err === 1'b1)
        err_cnt = err_cnt + 1;
      prev_ncs = sid_n_cs;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearLog();
    wr_addr.delete();
    wr_data.delete();
    wr_start.delete();
    wr_span.delete();
    err_cnt = 0;
  endtask

  // Presents one byte and returns at the negedge after it has been accepted.
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    host_tdata  = b;
    host_tvalid = 1'b1;
    n = 0;
    forever begin
      #1;
      if (host_tready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        break;
      end
      stall_cnt = stall_cnt + 1;
      @(negedge clk);
      n = n + 1;
      if (n > 1000) begin
        checkOutput("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  task automatic idleHost();
    host_tvalid = 1'b0;
    host_tdata  = 8'h00;
  endtask

  task automatic waitQuiet();
    int n;
    n = 0;
    while (!(busy === 1'b0 && sid_n_cs === 1'b1) && n < 3000) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput("quiet_timeout", 32'(n < 3000), 32'd1);
  endtask

  task automatic waitBootDone();
`ifdef SID_INIT_ROM_EN
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput("boot_timeout", 32'(n < 3000), 32'd1);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_addr",  32'(sid_addr), 32'h00);
    checkOutput("rst_data",  32'(sid_data), 32'h00);
    checkOutput("rst_ncs",   32'(sid_n_cs), 32'd1);
    checkOutput("rst_ready", 32'(host_tready), 32'd0);
    checkOutput("rst_busy",  32'(busy), 32'd0);
    checkOutput("rst_err",   32'(addr_err), 32'd0);
    checkOutput("rst_init",  32'(init_done), 32'(EXP_INIT));

    clearLog();
    rst = 1'b0;
    @(negedge clk);
`ifdef SID_INIT_ROM_EN
    checkOutput("boot_ready_low", 32'(host_tready), 32'd0);
    waitBootDone();
    checkOutput("boot_count", 32'(wr_addr.size()), 32'd8);
    checkOutput("boot_spans", 32'(wr_span.size()), 32'd8);
    checkOutput("boot_ncs_at_init", 32'(sid_n_cs), 32'd1);
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      checkOutput($sformatf("boot_addr%0d", i), 32'(wr_addr[i]), 32'(BOOT_A[i]));
      checkOutput($sformatf("boot_data%0d", i), 32'(wr_data[i]), 32'(BOOT_D[i]));
      if (i < wr_span.size())
        checkOutput($sformatf("boot_span%0d", i), 32'(wr_span[i]), 32'(SPAN));
      if (i > 0)
        checkOutput($sformatf("boot_space%0d", i), 32'(wr_start[i] - wr_start[i-1]), 32'(SPACE));
    end
    waitQuiet();
`else
    checkOutput("post_rst_init",  32'(init_done), 32'd1);
    checkOutput("post_rst_ready", 32'(host_tready), 32'd1);
    repeat (40) @(negedge clk);
    checkOutput("no_spurious_writes", 32'(wr_addr.size()), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
`endif

    // Single host write.
    clearLog();
    applyStimulus(8'h04);
    applyStimulus(8'h41);
    idleHost();
    checkOutput("single_busy_set", 32'(busy), 32'd1);
    waitQuiet();
    checkOutput("single_count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      checkOutput("single_addr", 32'(wr_addr[0]), 32'h04);
      checkOutput("single_data", 32'(wr_data[0]), 32'h41);
    end
    if (wr_span.size() > 0)
      checkOutput("single_span", 32'(wr_span[0]), 32'(SPAN));
    checkOutput("single_busy_clr", 32'(busy), 32'd0);

    // Out-of-range address is dropped and the parser stays in ADDR.
    clearLog();
    applyStimulus(8'h20);
    applyStimulus(8'h05);
    applyStimulus(8'h10);
    idleHost();
    waitQuiet();
    checkOutput("err_pulses", 32'(err_cnt), 32'd1);
    checkOutput("err_count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      checkOutput("err_addr", 32'(wr_addr[0]), 32'h05);
      checkOutput("err_data", 32'(wr_data[0]), 32'h10);
    end

    // Back-to-back burst overfills the FIFO and must stall without loss.
    clearLog();
    stall_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'(i * 3));
      applyStimulus(8'hC0 + 8'(i));
    end
    idleHost();
    checkOutput("burst_stalled", 32'(stall_cnt > 0), 32'd1);
    waitQuiet();
    checkOutput("burst_count", 32'(wr_addr.size()), 32'd10);
    for (int i = 0; i < 10 && i < wr_addr.size(); i++) begin
      checkOutput($sformatf("burst_addr%0d", i), 32'(wr_addr[i]), 32'(i * 3));
      checkOutput($sformatf("burst_data%0d", i), 32'(wr_data[i]), 32'h0C0 + 32'(i));
    end
    if (wr_start.size() > 5)
      checkOutput("burst_space", 32'(wr_start[5] - wr_start[4]), 32'(SPACE));

    // Reset in the middle of a write with three entries still queued.
    clearLog();
    applyStimulus(8'h11); applyStimulus(8'h51);
    applyStimulus(8'h12); applyStimulus(8'h52);
    applyStimulus(8'h13); applyStimulus(8'h53);
    applyStimulus(8'h14); applyStimulus(8'h54);
    idleHost();
    begin
      int n;
      n = 0;
      while (sid_n_cs !== 1'b0 && n < 100) begin
        @(negedge clk);
        n = n + 1;
      end
    end
    checkOutput("midrst_ncs_low", 32'(sid_n_cs), 32'd0);
    checkOutput("midrst_started", 32'(wr_addr.size()), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ncs_high", 32'(sid_n_cs), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_ready", 32'(host_tready), 32'd0);
    checkOutput("midrst_init", 32'(init_done), 32'(EXP_INIT));
    rst = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("midrst_writes", 32'(wr_addr.size()), 32'(1 + BOOT_N));
`ifdef SID_INIT_ROM_EN
    if (wr_addr.size() > 1)
      checkOutput("midrst_boot_restart", 32'(wr_addr[1]), 32'h18);
    checkOutput("midrst_init_again", 32'(init_done), 32'd1);
`endif
    checkOutput("midrst_final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sid_write_sched.md
# sid_write_sched

Register-write scheduler for the mos6581 core: owns the SID register bus (`sid_addr`, `sid_data`, `sid_n_cs`) and shares it between a host byte stream and an optional built-in boot sequence. Host bytes arrive as address/data pairs from the UART receiver. Writes are queued in a small FIFO and issued to the SID aligned to the 1 MHz `clk_en` tick. It sits between `uart_rx` and `mos6581` in the top level, replacing ad-hoc write logic there.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: write-queue entries; power of two, ≥2.
- `HOLD_TICKS`, 1: `clk_en` periods `sid_n_cs` stays low per write; 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock (sysclk).
- `rst`  in  1  synchronous active-high reset.
- `clk_en`  in  1  1 MHz SID enable, one `clk` cycle wide.
- `host_tdata`  in  8  host byte.
- `host_tvalid`  in  1  host byte valid.
- `host_tready`  out  1  host byte accepted when high with `host_tvalid`.
- `sid_addr`  out  5  SID register address.
- `sid_data`  out  8  SID write data.
- `sid_n_cs`  out  1  SID chip select, active low.
- `busy`  out  1  FIFO non-empty or issue FSM not IDLE.
- `init_done`  out  1  boot sequence fully issued.
- `addr_err`  out  1  one-cycle pulse: host address byte > 0x1F discarded.

## Operation
- Host parser, states ADDR/DATA:
  - ADDR: accepted byte ≤ 0x1F is latched as the pending address; go to DATA. A byte > 0x1F is dropped, `addr_err` pulses, and the parser stays in ADDR.
  - DATA: the accepted byte plus the pending address are pushed to the FIFO; go to ADDR.
  - `host_tready` = `init_done` && !`rst` && (parser in ADDR || FIFO not full).
- Boot sequencer (macro-gated): after reset, pushes 8 entries in order, one per cycle while the FIFO is not full:
  - (0x18,0x08), (0x05,0xBE), (0x06,0xF8), (0x01,0x11), (0x00,0x25), (0x02,0x00), (0x03,0x08), (0x04,0x11).
  - Host bytes are not accepted until `init_done`.
- FIFO: push and pop in the same cycle leaves occupancy unchanged. Push while full cannot occur, because `host_tready` and the sequencer both gate on full. Entry order is preserved.
- Issue FSM:
  - IDLE: on `clk_en` with FIFO non-empty, pop the entry, load `sid_addr`/`sid_data`, set `sid_n_cs`=0, set hold count = `HOLD_TICKS`, go to ACTIVE.
  - ACTIVE: on each `clk_en`, decrement the count. On the tick where the count reaches 0, set `sid_n_cs`=1 and go to GAP.
  - GAP: on `clk_en`, go to IDLE.
- `sid_addr`/`sid_data` hold their last values between writes and change only on a load.
- `init_done` rises in the cycle the 8th boot write's `sid_n_cs` returns high; it stays high until `rst`.

## Timing
- Reset values: `sid_addr`=0, `sid_data`=0, `sid_n_cs`=1, `host_tready`=0, `busy`=0, `addr_err`=0. `init_done`=0 with the macro, 1 without.
- All outputs are registered except `host_tready`, which is combinational from registered state.
- Latency: a pushed entry reaching an empty FIFO in IDLE loads on the next `clk_en` tick; `sid_n_cs` falls 1 `clk` after that tick.
- `sid_n_cs` low span is exactly `HOLD_TICKS` `clk_en` periods. Minimum write spacing is `HOLD_TICKS`+2 ticks.
- `rst` asserted at any point, including mid-write:
  - `sid_n_cs`=1 on the next cycle.
  - FIFO flushed, parser returned to ADDR, FSM returned to IDLE.
  - Boot sequence restarts from entry 0 after release.
- `clk_en` high in the same cycle as `rst`: ignored.

## Configuration
- `SID_INIT_ROM_EN` defined: boot sequencer compiled in; `init_done` behaves as specified in Operation.
- `SID_INIT_ROM_EN` not defined: boot sequencer absent, `init_done` is tied to 1, and the host path is live from the first cycle after reset.

## Test plan
- Macro on, reset release, `clk_en` every 50 clk → 8 writes in the listed order, `sid_n_cs` low for 50 clk each, spacing 150 clk, `init_done` rises after the 8th write.
- After `init_done`, host sends 0x04, 0x41 → one write with addr 0x04, data 0x41, and `busy` returns to 0.
- Host sends 0x20, 0x05, 0x10 → `addr_err` pulses once, single write (0x05,0x10), and no write to addr 0x00 or 0x20.
- Host bursts 10 pairs back-to-back, `FIFO_DEPTH`=4 → `host_tready` deasserts in DATA while full; all 10 writes appear in order and none is lost.
- `rst` pulsed while `sid_n_cs`=0 with 3 entries queued → `sid_n_cs`=1 next cycle, queued entries never issued, and the boot sequence restarts.
- Macro off → `init_done`=1 and `host_tready`=1 on the cycle after reset release, and no writes occur without host input.
